// File: rtl/srt_radix4_booth_mult_seq_if.sv
// srt_radix4_booth_mult_seq_if: start/done handshake and operand/result bus of the radix-4 Booth multiplier.
// Signals:
//   start        request from master, accepted only while ready=1
//   multiplicand unsigned operand A, sampled on accepted start
//   multiplier   unsigned operand B, sampled on accepted start
//   ready        slave can accept a start (IDLE or DONE)
//   done         one-cycle pulse, product valid from this cycle on
//   digit_out    signed Booth digit applied this cycle, 0 outside CALC
//   product_out  unsigned A*B, held until the next result
// Modports: master drives requests, slave (the multiplier) drives results.
interface srt_radix4_booth_mult_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      start;
  logic [DATA_WIDTH-1:0]     multiplicand;
  logic [DATA_WIDTH-1:0]     multiplier;
  logic                      ready;
  logic                      done;
  logic [2:0]                digit_out;
  logic [2*DATA_WIDTH-1:0]   product_out;
  modport master (output start, multiplicand, multiplier, input ready, done, digit_out, product_out);
  modport slave  (input start, multiplicand, multiplier, output ready, done, digit_out, product_out);
endinterface

// File: rtl/srt_radix4_booth_mult_seq.sv
// srt_radix4_booth_mult_seq: sequential unsigned multiplier, radix-4 Booth digits MSB first, shift-left-2-then-add.
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      slave side of srt_radix4_booth_mult_seq_if (start/operands in, ready/done/digit/product out)
// Optional: define SRT_MULT_ZERO_SKIP_EN to finish in one cycle when either operand is zero.
module srt_radix4_booth_mult_seq #(
  parameter int DATA_WIDTH = 32
) (
  input logic                          clk,
  input logic                          reset_n,
  srt_radix4_booth_mult_seq_if.slave   bus
);
  localparam int NUM_DIGITS = DATA_WIDTH / 2 + 1;
  localparam int EW = DATA_WIDTH + 3;
  localparam int AW = 2 * DATA_WIDTH + 2;
  localparam int IW = $clog2(NUM_DIGITS);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [EW-1:0]           ext_q;
  logic [AW-1:0]           acc_q;
  logic [IW-1:0]           idx_q;
  logic [2:0]              digit_q;
  logic                    ready_q;
  logic                    done_q;
  logic [2*DATA_WIDTH-1:0] product_q;
  logic [EW-1:0]           ext_init;
  logic [EW-1:0]           mag;
  logic [EW-1:0]           pp;
  logic [AW-1:0]           acc_d;
  // Booth value of a triplet is -2*t2 + t1 + t0, taken mod 8 as a 3-bit two's complement digit.
  function automatic logic [2:0] recode(input logic [2:0] t);
    return {2'b00, t[1]} + {2'b00, t[0]} + {t[2], t[2], 1'b0};
  endfunction
  // ext is consumed from the top: each CALC cycle shifts it left by 2 so the current triplet is always its top 3 bits.
  assign ext_init = {2'b00, bus.multiplier, 1'b0};
  always_comb begin
    mag   = digit_q[0] ? {3'b000, a_q} : digit_q[1] ? {2'b00, a_q, 1'b0} : '0;
    pp    = digit_q[2] ? -mag : mag;
    acc_d = (acc_q << 2) + {{(AW-EW){pp[EW-1]}}, pp};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      ext_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      digit_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      product_q <= '0;
    end else if (bus.start && ready_q) begin
      a_q    <= bus.multiplicand;
      ext_q  <= ext_init;
      acc_q  <= '0;
      idx_q  <= IW'(NUM_DIGITS - 1);
`ifdef SRT_MULT_ZERO_SKIP_EN
      if (bus.multiplicand == '0 || bus.multiplier == '0) begin
        state_q   <= DONE;
        ready_q   <= 1'b1;
        done_q    <= 1'b1;
        digit_q   <= '0;
        product_q <= '0;
      end else begin
        state_q <= CALC;
        ready_q <= 1'b0;
        done_q  <= 1'b0;
        digit_q <= recode(ext_init[EW-1 -: 3]);
      end
`else
      state_q <= CALC;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      digit_q <= recode(ext_init[EW-1 -: 3]);
`endif
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      ext_q <= ext_q << 2;
      if (idx_q == '0) begin
        state_q   <= DONE;
        ready_q   <= 1'b1;
        done_q    <= 1'b1;
        digit_q   <= '0;
        product_q <= acc_d[2*DATA_WIDTH-1:0];
      end else begin
        idx_q   <= idx_q - 1'b1;
        digit_q <= recode(ext_q[EW-3 -: 3]);
      end
    end else begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end
  end
  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.digit_out   = digit_q;
  assign bus.product_out = product_q;
endmodule

// File: tb/tb_srt_radix4_booth_mult_seq.sv
// tb_srt_radix4_booth_mult_seq: scoreboard bench for the radix-4 Booth multiplier at DATA_WIDTH=8.
module tb_srt_radix4_booth_mult_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  typedef struct {
    logic [15:0] p;
    int          c;
  } exp_t;
  exp_t q[$];
  srt_radix4_booth_mult_seq_if #(.DATA_WIDTH(8)) bus();
  srt_radix4_booth_mult_seq #(.DATA_WIDTH(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int lat_of(input logic [7:0] a, input logic [7:0] b);
`ifdef SRT_MULT_ZERO_SKIP_EN
    return (a == 0 || b == 0) ? 1 : 6;
`else
    return 6;
`endif
  endfunction
  always @(negedge clk) begin
    chk("digit_range", {31'd0, (bus.digit_out != 3'b011 && bus.digit_out != 3'b100) && (!bus.ready || bus.digit_out == 3'd0)}, 32'd1);
    if (reset_n && bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product", {16'd0, bus.product_out}, {16'd0, e.p});
        chk("latency", cyc, e.c);
      end
    end
  end
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push, input logic [15:0] p);
    int i;
    for (i = 0; i < 20 && !bus.ready; i++) @(negedge clk);
    if (!bus.ready) chk("ready_timeout", 32'd0, 32'd1);
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    if (push) q.push_back('{p: p, c: cyc + lat_of(a, b)});
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    int i;
    for (i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    logic [2:0] dseq [5];
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_digit", {29'd0, bus.digit_out}, 32'd0);
    chk("rst_product", {16'd0, bus.product_out}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    dseq = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b111};
    issue(8'hFF, 8'hFF, 1'b1, 16'hFE01);
    for (int i = 0; i < 5; i++) begin
      chk("digit_ff", {29'd0, bus.digit_out}, {29'd0, dseq[i]});
      if (i < 4) @(negedge clk);
    end
    wait_done();
    @(negedge clk);
    issue(8'h80, 8'h03, 1'b1, 16'h0180);
    wait_done();
    issue(8'h01, 8'h01, 1'b1, 16'h0001);
    wait_done();
    @(negedge clk);
    issue(8'h12, 8'h34, 1'b1, 16'h03A8);
    bus.start = 1'b1;
    bus.multiplicand = 8'h05;
    bus.multiplier = 8'h07;
    chk("ready_in_calc", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ready_in_calc2", {31'd0, bus.ready}, 32'd0);
    wait_done();
    @(negedge clk);
    issue(8'h12, 8'h34, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_product", {16'd0, bus.product_out}, 32'd0);
    chk("mid_rst_digit", {29'd0, bus.digit_out}, 32'd0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(8'h00, 8'hAB, 1'b1, 16'h0000);
    wait_done();
    @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      issue(a, b, 1'b1, 16'(a) * 16'(b));
    end
    wait_done();
    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
